// File: rtl/crc_pkg.sv
// Shared definitions for the CRC transmitter/receiver pair. Both ends take
// their default widths and generator polynomial from here so they cannot drift.
package crc_pkg;

  localparam int DEF_BW = 4;
  localparam int DEF_CRC_BW = 3;
  localparam logic [DEF_CRC_BW:0] DEF_DIVISOR = 4'b1011;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } crc_state_t;

endpackage

// File: rtl/crc_transmitter_if.sv
// Input word handshake and output codeword handshake of the CRC transmitter.
// slave is the encoder's view; master is the view of whatever drives it.
interface crc_transmitter_if
  import crc_pkg::*;
#(
  parameter int BW     = DEF_BW,
  parameter int CRC_BW = DEF_CRC_BW
);

  logic [BW-1:0]        in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [BW+CRC_BW-1:0] out_code;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_valid
  );

endinterface

// File: rtl/crc_serial_step.sv
// One bit of MSB-first polynomial division: folds data bit d into the running
// remainder. Purely combinational.
module crc_serial_step #(
  parameter int CRC_BW = 3
) (
  input  logic [CRC_BW-1:0] rem,
  input  logic              d,
  input  logic [CRC_BW-1:0] poly,
  output logic [CRC_BW-1:0] rem_next
);

  logic fb;

  // Feedback is the bit that falls out of the top of the remainder, mixed with the data bit.
  assign fb = rem[CRC_BW-1] ^ d;

  // Shift left by one and conditionally subtract (XOR) the polynomial's low bits.
  genvar gi;
  generate
    for (gi = 0; gi < CRC_BW; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign rem_next[gi] = fb & poly[gi];
      end else begin : g_upper
        assign rem_next[gi] = rem[gi-1] ^ (fb & poly[gi]);
      end
    end
  endgenerate

endmodule

// File: rtl/crc_transmitter.sv
// Bit-serial CRC encoder. Accepts a data word, divides it MSB-first over BW
// cycles, then holds {data, remainder} until downstream takes it. Counts
// delivered frames (wrapping counter).
module crc_transmitter
  import crc_pkg::*;
#(
  parameter int                BW      = DEF_BW,
  parameter int                CRC_BW  = DEF_CRC_BW,
  parameter logic [CRC_BW:0]   DIVISOR = DEF_DIVISOR,
  parameter int                CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  crc_transmitter_if.slave  bus,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int CNTB = (BW > 1) ? $clog2(BW) : 1;

  // Refuse to build with a degenerate polynomial or widths.
  generate
    if (CRC_BW < 1 || BW < 1 || DIVISOR[CRC_BW] != 1'b1) begin : g_bad_params
      $error("crc_transmitter: need BW>=1, CRC_BW>=1 and DIVISOR MSB set");
    end
  endgenerate

  crc_state_t            state, state_next;
  logic [BW-1:0]         data_reg;
  logic [BW-1:0]         shift_reg;
  logic [CRC_BW-1:0]     rem_reg;
  logic [CRC_BW-1:0]     rem_next;
  logic [CNTB-1:0]       cnt_reg;
  logic [BW+CRC_BW-1:0]  code_reg;
  logic                  valid_reg;
  logic [CNT_W-1:0]      frame_cnt_reg;
  logic                  last_bit;

  assign last_bit = (cnt_reg == '0);

  crc_serial_step #(.CRC_BW(CRC_BW)) u_step (
    .rem      (rem_reg),
    .d        (shift_reg[BW-1]),
    .poly     (DIVISOR[CRC_BW-1:0]),
    .rem_next (rem_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the state-decoded handshake outputs.
  always_comb begin
    state_next  = state;
    bus.in_ready = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy        = 1'b0;
        if (bus.in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture word, shift one bit per cycle, publish and count frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg      <= '0;
      shift_reg     <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      code_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_reg  <= bus.in_data;
            shift_reg <= bus.in_data;
            rem_reg   <= '0;
            cnt_reg   <= CNTB'(BW - 1);
          end
        end
        SHIFT: begin
          rem_reg   <= rem_next;
          shift_reg <= shift_reg << 1;
          cnt_reg   <= cnt_reg - 1'b1;
          if (last_bit) begin
            code_reg  <= {data_reg, rem_next};
            valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_reg     <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_code  = code_reg;
  assign bus.out_valid = valid_reg;
  assign frame_cnt     = frame_cnt_reg;

endmodule
